// File: rtl/mvb_fork_sel_pkg.sv
// Shared helpers for mvb_fork_sel: select-bit indexing, item popcount, counter increment width.
package mvb_fork_sel_pkg;

  // Upper bound on ITEMS accepted by popcount(); narrower vectors are zero-extended.
  localparam int MAX_ITEMS = 64;
  localparam int ITEMS_DEF = 4;
  localparam int INC_W_DEF = $clog2(ITEMS_DEF + 1);

  function automatic int sel_bit(input int i, input int p, input int output_ports);
    return i * output_ports + p;
  endfunction

  function automatic int inc_width(input int items);
    return $clog2(items + 1);
  endfunction

  function automatic int popcount(input logic [MAX_ITEMS-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < MAX_ITEMS; k++) n += int'(v[k]);
    return n;
  endfunction

endpackage

// File: rtl/mvb_fork_sel_port.sv
// One TX port of mvb_fork_sel: item masking, done flag, handshake and optional item counter.
// Optional build macro: MVB_FORK_SEL_STATS_EN adds the delivered-item counter.
module mvb_fork_sel_port
  import mvb_fork_sel_pkg::*;
#(
  parameter int ITEMS       = 4,
  parameter int USE_DST_RDY = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_src_rdy,
  input  logic                 i_rx_xfer,
  input  logic [ITEMS-1:0]     i_vld,
  input  logic [ITEMS-1:0]     i_sel,
  input  logic                 i_dst_rdy,
`ifdef MVB_FORK_SEL_STATS_EN
  input  logic                 i_stat_clr,
  output logic [CNT_WIDTH-1:0] o_stat_items,
`endif
  output logic [ITEMS-1:0]     o_vld,
  output logic                 o_src_rdy,
  output logic                 o_sat
);

  logic r_done;
  logic w_need;
  logic w_dst_rdy;
  logic w_hs;

  assign o_vld     = i_vld & i_sel;
  assign w_need    = |o_vld;
  assign w_dst_rdy = (USE_DST_RDY != 0) ? i_dst_rdy : 1'b1;
  assign o_src_rdy = i_rx_src_rdy & w_need & ~r_done & ~i_rst;
  assign w_hs      = o_src_rdy & w_dst_rdy;
  assign o_sat     = ~w_need | r_done | w_hs;

  // NOTE: state uses non-blocking assignments with reset sampled on the clock edge,
  // so every flop sees pre-edge values regardless of always_ff evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_done <= 1'b0;
    else if (i_rx_xfer) r_done <= 1'b0;  // word completion wins over a same-cycle accept
    else if (w_hs)      r_done <= 1'b1;
  end

`ifdef MVB_FORK_SEL_STATS_EN
  localparam int INC_W = inc_width(ITEMS);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [INC_W-1:0]     w_inc;

  assign w_inc        = INC_W'(popcount(MAX_ITEMS'(o_vld)));
  assign o_stat_items = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_stat_clr) r_cnt <= '0;
    else if (w_hs)           r_cnt <= r_cnt + CNT_WIDTH'(w_inc);
  end
`endif

endmodule

// File: rtl/mvb_fork_sel.sv
// MVB fork with per-item port selection; each RX word is held until every selected port accepts.
// Optional build macro: MVB_FORK_SEL_STATS_EN adds STAT_CLR / STAT_ITEMS per-port item counters.
module mvb_fork_sel
  import mvb_fork_sel_pkg::*;
#(
  parameter int OUTPUT_PORTS = 2,
  parameter int ITEMS        = 4,
  parameter int ITEM_WIDTH   = 8,
  parameter int USE_DST_RDY  = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                                     CLK,
  input  logic                                     RESET,
  input  logic [ITEMS*ITEM_WIDTH-1:0]              RX_DATA,
  input  logic [ITEMS-1:0]                         RX_VLD,
  input  logic [ITEMS*OUTPUT_PORTS-1:0]            RX_SEL,
  input  logic                                     RX_SRC_RDY,
  output logic                                     RX_DST_RDY,
  output logic [OUTPUT_PORTS*ITEMS*ITEM_WIDTH-1:0] TX_DATA,
  output logic [OUTPUT_PORTS*ITEMS-1:0]            TX_VLD,
  output logic [OUTPUT_PORTS-1:0]                  TX_SRC_RDY,
  input  logic [OUTPUT_PORTS-1:0]                  TX_DST_RDY
`ifdef MVB_FORK_SEL_STATS_EN
  ,
  input  logic                                     STAT_CLR,
  output logic [OUTPUT_PORTS*CNT_WIDTH-1:0]        STAT_ITEMS
`endif
);

  logic [OUTPUT_PORTS-1:0] w_sat;
  logic                    w_rx_xfer;

  // An idle bus is always "ready" so stale RX_VLD/RX_SEL never block it.
  assign RX_DST_RDY = ~RESET & (~RX_SRC_RDY | (&w_sat));
  assign w_rx_xfer  = RX_SRC_RDY & RX_DST_RDY;
  assign TX_DATA    = {OUTPUT_PORTS{RX_DATA}};

  for (genvar p = 0; p < OUTPUT_PORTS; p++) begin : g_port
    logic [ITEMS-1:0] w_sel;

    for (genvar i = 0; i < ITEMS; i++) begin : g_item
      assign w_sel[i] = RX_SEL[sel_bit(i, p, OUTPUT_PORTS)];
    end

    mvb_fork_sel_port #(
      .ITEMS       (ITEMS),
      .USE_DST_RDY (USE_DST_RDY),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_port (
      .i_clk        (CLK),
      .i_rst        (RESET),
      .i_rx_src_rdy (RX_SRC_RDY),
      .i_rx_xfer    (w_rx_xfer),
      .i_vld        (RX_VLD),
      .i_sel        (w_sel),
      .i_dst_rdy    (TX_DST_RDY[p]),
`ifdef MVB_FORK_SEL_STATS_EN
      .i_stat_clr   (STAT_CLR),
      .o_stat_items (STAT_ITEMS[p*CNT_WIDTH +: CNT_WIDTH]),
`endif
      .o_vld        (TX_VLD[p*ITEMS +: ITEMS]),
      .o_src_rdy    (TX_SRC_RDY[p]),
      .o_sat        (w_sat[p])
    );
  end

endmodule

// File: tb/tb_mvb_fork_sel.sv
// Self-checking bench for mvb_fork_sel: directed routing/stall/reset cases plus a random scoreboard run.
module tb_mvb_fork_sel;

  localparam int P  = 2;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 32;
`ifdef MVB_FORK_SEL_STATS_EN
  localparam int NWORDS = 2000;
`else
  localparam int NWORDS = 300;
`endif

  logic             CLK = 1'b0;
  logic             RESET;
  logic [N*W-1:0]   RX_DATA;
  logic [N-1:0]     RX_VLD;
  logic [N*P-1:0]   RX_SEL;
  logic             RX_SRC_RDY;
  logic             RX_DST_RDY;
  logic [P*N*W-1:0] TX_DATA;
  logic [P*N-1:0]   TX_VLD;
  logic [P-1:0]     TX_SRC_RDY;
  logic [P-1:0]     TX_DST_RDY;
  logic             STAT_CLR;
  logic [P*CW-1:0]  STAT_ITEMS;

  typedef struct {
    logic [N-1:0]   vld;
    logic [N*W-1:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [CW-1:0] cnt [P];
  int          total = 0;
  int          bad   = 0;

  mvb_fork_sel #(
    .OUTPUT_PORTS (P),
    .ITEMS        (N),
    .ITEM_WIDTH   (W),
    .USE_DST_RDY  (1),
    .CNT_WIDTH    (CW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RX_DATA    (RX_DATA),
    .RX_VLD     (RX_VLD),
    .RX_SEL     (RX_SEL),
    .RX_SRC_RDY (RX_SRC_RDY),
    .RX_DST_RDY (RX_DST_RDY),
    .TX_DATA    (TX_DATA),
    .TX_VLD     (TX_VLD),
    .TX_SRC_RDY (TX_SRC_RDY),
`ifdef MVB_FORK_SEL_STATS_EN
    .TX_DST_RDY (TX_DST_RDY),
    .STAT_CLR   (STAT_CLR),
    .STAT_ITEMS (STAT_ITEMS)
`else
    .TX_DST_RDY (TX_DST_RDY)
`endif
  );

`ifndef MVB_FORK_SEL_STATS_EN
  assign STAT_ITEMS = '0;
`endif

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input int p, input exp_t e);
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic int q_size(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t pop_exp(input int p);
    return (p == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  // Present a word and push what each port should receive from it.
  task automatic setup(input logic [N*W-1:0] d, input logic [N-1:0] v, input logic [N*P-1:0] s);
    exp_t e;
    RX_DATA    = d;
    RX_VLD     = v;
    RX_SEL     = s;
    RX_SRC_RDY = 1'b1;
    for (int p = 0; p < P; p++) begin
      e.data = d;
      for (int i = 0; i < N; i++) e.vld[i] = v[i] & s[i*P + p];
      if (e.vld != '0) push_exp(p, e);
    end
  endtask

  task automatic send(input logic [N*W-1:0] d, input logic [N-1:0] v, input logic [N*P-1:0] s);
    setup(d, v, s);
    for (int c = 0; c < 64; c++) begin
      TX_DST_RDY = P'($urandom);
      @(negedge CLK);
      if (RX_DST_RDY) break;
      if (c == 63) check("word_timeout", 64'd0, 64'd1);
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    RX_SRC_RDY = 1'b0;
  endtask

  // Scoreboard: every accepted port transfer must match the oldest expectation for that port.
  always @(negedge CLK) begin
    exp_t e;
    for (int p = 0; p < P; p++) begin
      if (TX_SRC_RDY[p] && TX_DST_RDY[p]) begin
        if (q_size(p) == 0) begin
          check($sformatf("unexpected_p%0d", p), 64'd1, 64'd0);
        end else begin
          e = pop_exp(p);
          check($sformatf("vld_p%0d", p), 64'(TX_VLD[p*N +: N]), 64'(e.vld));
          check($sformatf("data_p%0d", p), 64'(TX_DATA[p*N*W +: N*W]), 64'(e.data));
          cnt[p] = cnt[p] + CW'($countones(e.vld));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    for (int p = 0; p < P; p++) cnt[p] = '0;
    RESET      = 1'b1;
    RX_DATA    = 32'hCAFEF00D;
    RX_VLD     = '1;
    RX_SEL     = '1;
    RX_SRC_RDY = 1'b1;
    TX_DST_RDY = '1;
    STAT_CLR   = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_tx_src_rdy", 64'(TX_SRC_RDY), 64'd0);
    check("rst_rx_dst_rdy", 64'(RX_DST_RDY), 64'd0);
    @(posedge CLK); #1;
    RESET      = 1'b0;
    RX_SRC_RDY = 1'b0;
    @(negedge CLK);
    check("idle_rx_dst_rdy", 64'(RX_DST_RDY), 64'd1);
    check("idle_tx_src_rdy", 64'(TX_SRC_RDY), 64'd0);

    // Broadcast to both ports in a single cycle
    @(posedge CLK); #1;
    TX_DST_RDY = 2'b11;
    setup(32'hA1B2C3D4, 4'b1111, 8'hFF);
    @(negedge CLK);
    check("bc_tx_vld", 64'(TX_VLD), 64'hFF);
    check("bc_tx_src_rdy", 64'(TX_SRC_RDY), 64'h3);
    check("bc_rx_dst_rdy", 64'(RX_DST_RDY), 64'd1);
    @(posedge CLK); #1;

    // Split routing: items 0,1 to port0, items 2,3 to port1
    setup(32'h11223344, 4'b1111, 8'b1010_0101);
    @(negedge CLK);
    check("split_tx_vld", 64'(TX_VLD), 64'hC3);
    check("split_tx_src_rdy", 64'(TX_SRC_RDY), 64'h3);
    check("split_rx_dst_rdy", 64'(RX_DST_RDY), 64'd1);
    @(posedge CLK); #1;

    // Stall port1 for 5 cycles; port0 must accept exactly once
    TX_DST_RDY = 2'b01;
    setup(32'h55667788, 4'b1111, 8'hFF);
    @(negedge CLK);
    check("stall_c1_src", 64'(TX_SRC_RDY), 64'h3);
    check("stall_c1_rdy", 64'(RX_DST_RDY), 64'd0);
    for (int c = 2; c <= 5; c++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      check($sformatf("stall_c%0d_src", c), 64'(TX_SRC_RDY), 64'h2);
      check($sformatf("stall_c%0d_rdy", c), 64'(RX_DST_RDY), 64'd0);
    end
    @(posedge CLK); #1;
    TX_DST_RDY = 2'b11;
    @(negedge CLK);
    check("stall_c6_src", 64'(TX_SRC_RDY), 64'h2);
    check("stall_c6_rdy", 64'(RX_DST_RDY), 64'd1);
    @(posedge CLK); #1;
    RX_SRC_RDY = 1'b0;
    @(negedge CLK);
    check("stall_after_src", 64'(TX_SRC_RDY), 64'd0);

    // Word with no selected item is dropped in one cycle
    @(posedge CLK); #1;
    setup(32'hDEADBEEF, 4'b1010, 8'h00);
    @(negedge CLK);
    check("empty_src", 64'(TX_SRC_RDY), 64'd0);
    check("empty_rdy", 64'(RX_DST_RDY), 64'd1);
    @(posedge CLK); #1;

    // Reset after port0 accepted: the held word goes to both ports again
    TX_DST_RDY = 2'b01;
    setup(32'h0BADF00D, 4'b1111, 8'hFF);
    @(negedge CLK);
    check("rmid_c1_src", 64'(TX_SRC_RDY), 64'h3);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("rmid_rst_src", 64'(TX_SRC_RDY), 64'd0);
    check("rmid_rst_rdy", 64'(RX_DST_RDY), 64'd0);
    @(posedge CLK); #1;
    RESET      = 1'b0;
    TX_DST_RDY = 2'b11;
    e.vld      = 4'b1111;
    e.data     = 32'h0BADF00D;
    push_exp(0, e);
    @(negedge CLK);
    check("rmid_re_src", 64'(TX_SRC_RDY), 64'h3);
    check("rmid_re_rdy", 64'(RX_DST_RDY), 64'd1);
    @(posedge CLK); #1;
    RX_SRC_RDY = 1'b0;

    // Align counters and model before the random run
    STAT_CLR = 1'b1;
    @(posedge CLK); #1;
    STAT_CLR = 1'b0;
    for (int p = 0; p < P; p++) cnt[p] = '0;

    for (int k = 0; k < NWORDS; k++) begin
      send(32'($urandom), N'($urandom), (N*P)'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
    end
    TX_DST_RDY = 2'b11;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("drain_q0", 64'(q0.size()), 64'd0);
    check("drain_q1", 64'(q1.size()), 64'd0);

`ifdef MVB_FORK_SEL_STATS_EN
    for (int p = 0; p < P; p++)
      check($sformatf("stat_p%0d", p), 64'(STAT_ITEMS[p*CW +: CW]), 64'(cnt[p]));
    @(posedge CLK); #1;
    STAT_CLR = 1'b1;
    @(posedge CLK); #1;
    STAT_CLR = 1'b0;
    @(negedge CLK);
    for (int p = 0; p < P; p++)
      check($sformatf("stat_clr_p%0d", p), 64'(STAT_ITEMS[p*CW +: CW]), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
